// File: rtl/draw_wrbuf_pkg.sv
// rtl/draw_wrbuf_pkg.sv - shared types and width helpers for the draw write buffer
package draw_wrbuf_pkg;

    localparam int DATA_W  = 64;
    localparam int BE_W    = 8;
    localparam int ENTRY_W = DATA_W + BE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } wrbuf_state_e;

    // Burst length field must hold the value BURST itself, hence the extra bit
    function automatic int len_w(input int burst);
        return $clog2(burst) + 1;
    endfunction

    // Occupancy counter must hold the value DEPTH itself, hence the extra bit
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/draw_wrbuf_fifo.sv
// rtl/draw_wrbuf_fifo.sv - first-word-fall-through pixel FIFO with registered status
module draw_wrbuf_fifo
    import draw_wrbuf_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int AF_LEVEL = 504,
    parameter int CNT_W    = 10
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               afull_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               full_q;
    logic               empty_q;
    logic               afull_q;
    logic               push_ok;
    logic               pop_ok;

    // Guard both ends here so callers can never corrupt the pointers
    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Next occupancy; simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers and status flags, all derived from the next occupancy so they line up with count
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
            afull_q <= (count_d >= CNT_W'(AF_LEVEL));
        end
    end

    // Storage array; contents are don't-care after a clear since the pointers reset
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign afull_o = afull_q;

endmodule

// File: rtl/draw_wrbuf.sv
// rtl/draw_wrbuf.sv - pixel write buffer draining to the VIF as incrementing bursts
module draw_wrbuf
    import draw_wrbuf_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int BURST = 8,
    parameter int ADR_W = 29
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    INIT,
    input  logic                    ADR_SET,
    input  logic [ADR_W-1:0]        ADR_IN,
    input  logic                    BUF_WR,
    input  logic [DATA_W-1:0]       BUF_WDATA,
    input  logic [BE_W-1:0]         BUF_WBE,
    input  logic                    FLUSH,
    output logic                    VIF_DRWREQ,
    output logic [ADR_W-1:0]        VIF_DRWADR,
    output logic [len_w(BURST)-1:0] VIF_DRWLEN,
    input  logic                    VIF_DRWACK,
    input  logic                    VIF_DRWWDATARD,
    output logic [DATA_W-1:0]       VIF_DRWWDATA,
    output logic [BE_W-1:0]         VIF_DRWWBE,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    BUF_OVER,
    output logic                    VIF_UNDER,
    output logic                    BUSY,
    output logic                    FLUSH_DONE
);

    localparam int LEN_W = len_w(BURST);
    localparam int CNT_W = cnt_w(DEPTH);

    wrbuf_state_e       state_q;
    logic               req_q;
    logic [ADR_W-1:0]   adr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_q;
    logic               pend_q;
    logic               done_q;
    logic               over_q;
    logic               under_q;
    logic               busy_q;

    logic               clr;
    logic               pop;
    logic               last_beat;
    logic               adr_load;
    logic               drained;
    logic [ENTRY_W-1:0] f_head;
    logic [CNT_W-1:0]   f_count;
    logic               f_full;
    logic               f_empty;
    logic               f_afull;

    assign clr       = RST | INIT;
    assign pop       = (state_q == DATA) && VIF_DRWWDATARD;
    assign last_beat = pop && ((beat_q + LEN_W'(1)) == len_q);
    assign drained   = (state_q == IDLE) && f_empty;
    // Only retarget when truly quiescent, so a burst about to form can never see a moving address
    assign adr_load  = ADR_SET && !busy_q && drained && !pend_q;

    draw_wrbuf_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (DEPTH - BURST),
        .CNT_W    (CNT_W)
    ) u_fifo (
        .clk_i   (CLK),
        .clr_i   (clr),
        .push_i  (BUF_WR),
        .wdata_i ({BUF_WBE, BUF_WDATA}),
        .pop_i   (pop),
        .head_o  (f_head),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty),
        .afull_o (f_afull)
    );

    // Burst FSM: request, address/length capture, beat counting and address advance
    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            adr_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (adr_load) begin
                        adr_q <= ADR_IN;
                    end
                    if (f_count >= CNT_W'(BURST)) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        len_q   <= LEN_W'(BURST);
                    end else if (pend_q && (f_count != '0)) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        len_q   <= LEN_W'(f_count);
                    end
                end
                REQ: begin
                    if (VIF_DRWACK) begin
                        state_q <= DATA;
                        req_q   <= 1'b0;
                        beat_q  <= '0;
                    end
                end
                DATA: begin
                    if (pop) begin
                        beat_q <= beat_q + LEN_W'(1);
                        if (last_beat) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                            adr_q   <= adr_q + ADR_W'(len_q);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Flush tracking, error pulses and the busy flag
    always_ff @(posedge CLK) begin
        if (clr) begin
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
            under_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // A new FLUSH wins over completion of an older one so late words still get drained
            pend_q  <= FLUSH || (pend_q && !drained);
            done_q  <= pend_q && drained;
            over_q  <= BUF_WR && f_full;
            under_q <= VIF_DRWWDATARD && (state_q != DATA);
            busy_q  <= (state_q != IDLE) || !f_empty || pend_q;
        end
    end

    assign VIF_DRWREQ   = req_q;
    assign VIF_DRWADR   = adr_q;
    assign VIF_DRWLEN   = len_q;
    assign VIF_DRWWDATA = f_head[DATA_W-1:0];
    assign VIF_DRWWBE   = f_head[ENTRY_W-1:DATA_W];
    assign FULL         = f_full;
    assign EMPTY        = f_empty;
    assign ALMOST_FULL  = f_afull;
    assign BUF_OVER     = over_q;
    assign VIF_UNDER    = under_q;
    assign BUSY         = busy_q;
    assign FLUSH_DONE   = done_q;

endmodule

// File: tb/tb_draw_wrbuf.sv
// tb/tb_draw_wrbuf.sv - randomized self-checking bench for draw_wrbuf
module tb_draw_wrbuf;

    localparam int DEPTH = 512;
    localparam int BURST = 8;
    localparam int ADR_W = 29;

    logic              CLK = 1'b0;
    logic              RST;
    logic              INIT;
    logic              ADR_SET;
    logic [ADR_W-1:0]  ADR_IN;
    logic              BUF_WR;
    logic [63:0]       BUF_WDATA;
    logic [7:0]        BUF_WBE;
    logic              FLUSH;
    logic              VIF_DRWREQ;
    logic [ADR_W-1:0]  VIF_DRWADR;
    logic [3:0]        VIF_DRWLEN;
    logic              VIF_DRWACK;
    logic              VIF_DRWWDATARD;
    logic [63:0]       VIF_DRWWDATA;
    logic [7:0]        VIF_DRWWBE;
    logic              FULL;
    logic              EMPTY;
    logic              ALMOST_FULL;
    logic              BUF_OVER;
    logic              VIF_UNDER;
    logic              BUSY;
    logic              FLUSH_DONE;

    always #5 CLK = ~CLK;

    draw_wrbuf #(.DEPTH(DEPTH), .BURST(BURST), .ADR_W(ADR_W)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .INIT           (INIT),
        .ADR_SET        (ADR_SET),
        .ADR_IN         (ADR_IN),
        .BUF_WR         (BUF_WR),
        .BUF_WDATA      (BUF_WDATA),
        .BUF_WBE        (BUF_WBE),
        .FLUSH          (FLUSH),
        .VIF_DRWREQ     (VIF_DRWREQ),
        .VIF_DRWADR     (VIF_DRWADR),
        .VIF_DRWLEN     (VIF_DRWLEN),
        .VIF_DRWACK     (VIF_DRWACK),
        .VIF_DRWWDATARD (VIF_DRWWDATARD),
        .VIF_DRWWDATA   (VIF_DRWWDATA),
        .VIF_DRWWBE     (VIF_DRWWBE),
        .FULL           (FULL),
        .EMPTY          (EMPTY),
        .ALMOST_FULL    (ALMOST_FULL),
        .BUF_OVER       (BUF_OVER),
        .VIF_UNDER      (VIF_UNDER),
        .BUSY           (BUSY),
        .FLUSH_DONE     (FLUSH_DONE)
    );

    int nvec;
    int nerr;

    logic [71:0]      q[$];
    logic [ADR_W-1:0] m_adr;
    int               r_phase;
    int               r_left;
    int               r_wait;
    logic [3:0]       r_len;
    bit               vif_en;
    bit               force_rd;
    bit               exp_over;
    bit               exp_under;
    int               done_cnt;
    int               req_cnt;
    int               beat_cnt;
    logic [ADR_W-1:0] last_adr;
    int               last_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit wr, input bit fl, input bit ini, input bit aset, input logic [ADR_W-1:0] a);
        bit          was_data;
        bit          rd;
        bit          ack;
        logic [71:0] w;
        @(negedge CLK);
        check("buf_over", BUF_OVER, exp_over);
        check("vif_under", VIF_UNDER, exp_under);
        if (FLUSH_DONE) done_cnt++;
        ack = 1'b0;
        rd = 1'b0;
        was_data = (r_phase == 2);
        if (!ini) begin
            if (r_phase == 0 && vif_en && VIF_DRWREQ) begin
                req_cnt++;
                check("req_adr", VIF_DRWADR, m_adr);
                check("req_len_ok", (VIF_DRWLEN >= 1 && VIF_DRWLEN <= BURST && int'(VIF_DRWLEN) <= q.size()), 1);
                last_adr = VIF_DRWADR;
                last_len = int'(VIF_DRWLEN);
                r_len = VIF_DRWLEN;
                r_wait = $urandom_range(0, 3);
                r_phase = 1;
            end else if (r_phase == 1) begin
                check("req_hold", VIF_DRWREQ, 1);
                if (r_wait == 0) begin
                    ack = 1'b1;
                    r_phase = 2;
                    r_left = int'(r_len);
                end else begin
                    r_wait--;
                end
            end else if (r_phase == 2 && $urandom_range(0, 3) != 0) begin
                rd = 1'b1;
                if (q.size() == 0) begin
                    check("model_nonempty", 0, 1);
                end else begin
                    w = q.pop_front();
                    check("beat_data", VIF_DRWWDATA, w[63:0]);
                    check("beat_be", VIF_DRWWBE, w[71:64]);
                end
                beat_cnt++;
                r_left--;
                if (r_left == 0) begin
                    r_phase = 0;
                    m_adr = m_adr + ADR_W'(r_len);
                end
            end
            if (force_rd) rd = 1'b1;
        end
        exp_over = wr && FULL && !ini;
        exp_under = rd && !was_data;
        if (ini) begin
            q.delete();
            m_adr = '0;
            r_phase = 0;
        end
        if (aset) begin
            check("adrset_idle", BUSY, 0);
            m_adr = a;
        end
        w[63:0] = {$urandom, $urandom};
        w[71:64] = 8'($urandom);
        if (wr && !FULL && !ini) q.push_back(w);
        INIT = ini;
        FLUSH = fl;
        ADR_SET = aset;
        ADR_IN = a;
        BUF_WR = wr;
        BUF_WDATA = w[63:0];
        BUF_WBE = w[71:64];
        VIF_DRWACK = ack;
        VIF_DRWWDATARD = rd;
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        repeat (3) idle_tick();
        while (!(r_phase == 0 && EMPTY && !BUSY && !VIF_DRWREQ) && n < maxc) begin
            idle_tick();
            n++;
        end
        check("idle_reached", n < maxc, 1);
    endtask

    initial begin
        int d0;
        int rc;
        int b0;
        int n;
        nvec = 0; nerr = 0;
        m_adr = '0; r_phase = 0; r_left = 0; r_wait = 0; r_len = '0;
        vif_en = 1'b0; force_rd = 1'b0; exp_over = 1'b0; exp_under = 1'b0;
        done_cnt = 0; req_cnt = 0; beat_cnt = 0; last_adr = '0; last_len = 0;
        RST = 1'b1; INIT = 1'b0; ADR_SET = 1'b0; ADR_IN = '0; BUF_WR = 1'b0;
        BUF_WDATA = '0; BUF_WBE = '0; FLUSH = 1'b0; VIF_DRWACK = 1'b0; VIF_DRWWDATARD = 1'b0;

        repeat (3) idle_tick();
        check("rst_req", VIF_DRWREQ, 0);
        check("rst_adr", VIF_DRWADR, 0);
        check("rst_len", VIF_DRWLEN, 0);
        check("rst_wdata", VIF_DRWWDATA, 0);
        check("rst_wbe", VIF_DRWWBE, 0);
        check("rst_full", FULL, 0);
        check("rst_empty", EMPTY, 1);
        check("rst_afull", ALMOST_FULL, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", FLUSH_DONE, 0);
        RST = 1'b0;
        idle_tick();

        // full burst from a set address
        vif_en = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1, ADR_W'(32'h100));
        repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_idle(200);
        check("b8_adr", last_adr, 29'h100);
        check("b8_len", last_len, 8);
        check("b8_next_adr", VIF_DRWADR, 29'h108);

        // partial burst forced out by flush
        d0 = done_cnt;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(200);
        repeat (2) idle_tick();
        check("fl3_len", last_len, 3);
        check("fl3_done_once", done_cnt - d0, 1);
        check("fl3_busy", BUSY, 0);

        // fill with the VIF stalled
        vif_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
            if (i == DEPTH - BURST - 1) check("afull_503", ALMOST_FULL, 0);
            if (i == DEPTH - BURST) check("afull_504", ALMOST_FULL, 1);
            if (i == DEPTH - 1) check("full_511", FULL, 0);
        end
        idle_tick();
        check("full_512", FULL, 1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle_tick();
        check("over_pulse", BUF_OVER, 1);
        check("full_kept", FULL, 1);
        idle_tick();
        check("over_once", BUF_OVER, 0);
        vif_en = 1'b1;
        b0 = beat_cnt;
        wait_idle(5000);
        check("drain_512", beat_cnt - b0, 512);

        // address wrap
        tick(1'b0, 1'b0, 1'b0, 1'b1, {ADR_W{1'b1}} - ADR_W'(3));
        repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_idle(200);
        check("wrap_start", last_adr, 29'h1FFFFFFC);
        check("wrap_next", VIF_DRWADR, 4);

        // stray read outside a burst
        vif_en = 1'b0;
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) idle_tick();
        force_rd = 1'b1;
        idle_tick();
        force_rd = 1'b0;
        idle_tick();
        check("under_pulse", VIF_UNDER, 1);
        check("under_not_empty", EMPTY, 0);
        vif_en = 1'b1;
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(200);
        check("under_len", last_len, 2);

        // INIT in the middle of a burst
        repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        n = 0;
        while (!(r_phase == 2 && r_left == int'(r_len) - 3) && n < 200) begin
            idle_tick();
            n++;
        end
        check("init_reach", n < 200, 1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle_tick();
        check("init_empty", EMPTY, 1);
        check("init_req", VIF_DRWREQ, 0);
        check("init_adr", VIF_DRWADR, 0);
        check("init_busy", BUSY, 0);
        repeat (8) tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
        wait_idle(200);
        check("init_next_adr", last_adr, 0);

        // flush with nothing buffered
        d0 = done_cnt;
        rc = req_cnt;
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle_tick();
        check("efl_n1", FLUSH_DONE, 0);
        idle_tick();
        check("efl_n2", FLUSH_DONE, 1);
        idle_tick();
        check("efl_n3", FLUSH_DONE, 0);
        check("efl_noreq", req_cnt - rc, 0);
        check("efl_req", VIF_DRWREQ, 0);

        // random traffic with sporadic flushes
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), 1'b0, 1'b0, '0);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0);
        wait_idle(3000);
        check("rand_model_empty", q.size(), 0);
        check("rand_empty", EMPTY, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
